// File: rtl/imm_packer_pkg.sv
// Shared WISC ISA definitions for the immediate packer: opcode values,
// immediate classes, field widths and the opcode-to-class mapping.
package imm_packer_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned REGS_W  = 6;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned IMM5_W  = 5;
  localparam int unsigned IMM8_W  = 8;
  localparam int unsigned IMM11_W = 11;

  localparam logic [OPC_W-1:0] OP_J     = 5'b00100;
  localparam logic [OPC_W-1:0] OP_JR    = 5'b00101;
  localparam logic [OPC_W-1:0] OP_JAL   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_JALR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ADDI  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SUBI  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_XORI  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ANDNI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_BEQZ  = 5'b01100;
  localparam logic [OPC_W-1:0] OP_BNEZ  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_BLTZ  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_BGEZ  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_SLBI  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_LBI   = 5'b11000;

  typedef enum logic [2:0] {
    IMM_SIGN5,
    IMM_ZERO5,
    IMM_SIGN8,
    IMM_ZERO8,
    IMM_SIGN11
  } imm_class_e;

  // Anything not listed explicitly is an ALU-immediate form with a signed 5b field.
  function automatic imm_class_e imm_class_of(input logic [OPC_W-1:0] op);
    imm_class_e c;
    case (op)
      OP_J, OP_JAL:                         c = IMM_SIGN11;
      OP_LBI, OP_JR, OP_JALR,
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ:   c = IMM_SIGN8;
      OP_SLBI:                              c = IMM_ZERO8;
      OP_XORI, OP_ANDNI:                    c = IMM_ZERO5;
      default:                              c = IMM_SIGN5;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Input-entry and output-word handshake bundle for imm_packer.
interface imm_packer_if #(
  parameter int unsigned ADDR_W = 16
);
  import imm_packer_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OPC_W-1:0]     in_opcode;
  logic [REGS_W-1:0]    in_regs;
  logic [IMM_W-1:0]     in_imm;

  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [ADDR_W-1:0]    out_addr;

  modport slave (
    input  in_valid, in_opcode, in_regs, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_opcode, in_regs, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/imm_packer_range_check.sv
// Combinational immediate classifier: decides whether an immediate fits its
// opcode's field and builds the packed instruction word.
module imm_range_check
  import imm_packer_pkg::*;
(
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic [REGS_W-1:0]  i_regs,
  input  logic [IMM_W-1:0]   i_imm,
  output logic               o_fits,
  output logic [INSTR_W-1:0] o_instr
);

  imm_class_e w_class;
  logic       w_fit_s5;
  logic       w_fit_z5;
  logic       w_fit_s8;
  logic       w_fit_z8;
  logic       w_fit_s11;

  // Signed fit: every bit from the field's sign bit upward agrees.
  always_comb begin
    w_class   = imm_class_of(i_opcode);
    w_fit_s5  = (&i_imm[IMM_W-1:IMM5_W-1])  | ~(|i_imm[IMM_W-1:IMM5_W-1]);
    w_fit_z5  = ~(|i_imm[IMM_W-1:IMM5_W]);
    w_fit_s8  = (&i_imm[IMM_W-1:IMM8_W-1])  | ~(|i_imm[IMM_W-1:IMM8_W-1]);
    w_fit_z8  = ~(|i_imm[IMM_W-1:IMM8_W]);
    w_fit_s11 = (&i_imm[IMM_W-1:IMM11_W-1]) | ~(|i_imm[IMM_W-1:IMM11_W-1]);
  end

  always_comb begin
    o_fits  = 1'b0;
    o_instr = '0;
    case (w_class)
      IMM_SIGN11: begin
        o_fits  = w_fit_s11;
        o_instr = {i_opcode, i_imm[IMM11_W-1:0]};
      end
      IMM_SIGN8: begin
        o_fits  = w_fit_s8;
        o_instr = {i_opcode, i_regs[5:3], i_imm[IMM8_W-1:0]};
      end
      IMM_ZERO8: begin
        o_fits  = w_fit_z8;
        o_instr = {i_opcode, i_regs[5:3], i_imm[IMM8_W-1:0]};
      end
      IMM_ZERO5: begin
        o_fits  = w_fit_z5;
        o_instr = {i_opcode, i_regs, i_imm[IMM5_W-1:0]};
      end
      default: begin
        o_fits  = w_fit_s5;
        o_instr = {i_opcode, i_regs, i_imm[IMM5_W-1:0]};
      end
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready packer: S1 holds the raw entry and its fit result,
// S2 is the output register; out-of-range entries are dropped and counted.
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  imm_packer_if.slave      bus,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(2);

  logic                 r_s1_valid;
  logic [OPC_W-1:0]     r_s1_opcode;
  logic [REGS_W-1:0]    r_s1_regs;
  logic [IMM_W-1:0]     r_s1_imm;

  logic                 r_out_valid;
  logic [INSTR_W-1:0]   r_out_instr;
  logic [ADDR_W-1:0]    r_out_addr;
  logic [ADDR_W-1:0]    r_addr_cnt;

  logic                 r_err_flag;
  logic [CNT_W-1:0]     r_err_count;

  logic                 w_fits;
  logic [INSTR_W-1:0]   w_instr;
  logic                 w_s2_free;
  logic                 w_s1_adv;
  logic                 w_emit;
  logic                 w_drop;
  logic                 w_accept;
  logic                 w_in_ready;

  imm_range_check u_range_check (
    .i_opcode (r_s1_opcode),
    .i_regs   (r_s1_regs),
    .i_imm    (r_s1_imm),
    .o_fits   (w_fits),
    .o_instr  (w_instr)
  );

  // A drop never waits on S2, so a non-fitting S1 entry retires even when stalled.
  always_comb begin
    w_s2_free  = ~r_out_valid | bus.out_ready;
    w_s1_adv   = r_s1_valid & (~w_fits | w_s2_free);
    w_emit     = w_s1_adv & w_fits;
    w_drop     = w_s1_adv & ~w_fits;
    w_in_ready = ~clear & (~r_s1_valid | w_s1_adv);
    w_accept   = bus.in_valid & w_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_opcode <= '0;
      r_s1_regs   <= '0;
      r_s1_imm    <= '0;
    end else if (clear) begin
      r_s1_valid  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_opcode <= bus.in_opcode;
      r_s1_regs   <= bus.in_regs;
      r_s1_imm    <= bus.in_imm;
    end else if (w_s1_adv) begin
      r_s1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= START;
      r_addr_cnt  <= START;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_addr_cnt  <= START;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_instr;
      r_out_addr  <= r_addr_cnt;
      r_addr_cnt  <= r_addr_cnt + STEP;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
    end else if (clear) begin
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
    end else if (w_drop) begin
      r_err_flag  <= 1'b1;
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_addr  = r_out_addr;
  assign err_flag      = r_err_flag;
  assign err_count     = r_err_count;

endmodule
